// File: rtl/hazard_stall_controller.sv
// Hazard detection, operand forwarding and multi-cycle data-memory sequencing
// for the five-stage pipeline. Forward/stall/flush controls are combinational
// from the current pipeline state; the watchdog flag and stall counter are
// registered.
module hazard_stall_controller #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        HSC_CLK,
  input  logic        HSC_RST,
  input  logic [4:0]  HSC_RsD,
  input  logic [4:0]  HSC_RtD,
  input  logic [4:0]  HSC_RsE,
  input  logic [4:0]  HSC_RtE,
  input  logic [4:0]  HSC_WriteRegE,
  input  logic [4:0]  HSC_WriteRegM,
  input  logic [4:0]  HSC_WriteRegW,
  input  logic        HSC_RegWriteE,
  input  logic        HSC_RegWriteM,
  input  logic        HSC_RegWriteW,
  input  logic        HSC_MemToRegE,
  input  logic        HSC_MemToRegM,
  input  logic        HSC_BranchD,
  input  logic        HSC_MemReqM,
  input  logic        HSC_MemReadyM,
  output logic        HSC_StallF,
  output logic        HSC_StallD,
  output logic        HSC_StallE,
  output logic        HSC_StallM,
  output logic        HSC_FlushE,
  output logic        HSC_FlushW,
  output logic        HSC_ForwardAD,
  output logic        HSC_ForwardBD,
  output logic [1:0]  HSC_ForwardAE,
  output logic [1:0]  HSC_ForwardBE,
  output logic        HSC_MemTimeout,
  output logic [15:0] HSC_StallCount
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             timeout_r, timeout_nxt_s;
  logic [15:0]      stall_cnt_r;

  logic       lwstall_s, branchstall_s, memstall_s, stall_any_s;
  logic [1:0] fwd_ae_s, fwd_be_s;
  logic       fwd_ad_s, fwd_bd_s;

  // A source operand depends on a producer when the producer writes the same
  // nonzero register; register 0 is hardwired and never a hazard.
  function automatic logic src_hit(input logic [4:0] src, input logic [4:0] dst,
                                   input logic we);
    return we && (src != 5'd0) && (src == dst);
  endfunction

  // Forwarding selects and hazard/stall conditions from current pipeline state.
  always_comb begin
    fwd_ae_s      = 2'b00;
    fwd_be_s      = 2'b00;
    if (src_hit(HSC_RsE, HSC_WriteRegM, HSC_RegWriteM)) begin
      fwd_ae_s = 2'b10;
    end else if (src_hit(HSC_RsE, HSC_WriteRegW, HSC_RegWriteW)) begin
      fwd_ae_s = 2'b01;
    end else begin
      fwd_ae_s = 2'b00;
    end
    if (src_hit(HSC_RtE, HSC_WriteRegM, HSC_RegWriteM)) begin
      fwd_be_s = 2'b10;
    end else if (src_hit(HSC_RtE, HSC_WriteRegW, HSC_RegWriteW)) begin
      fwd_be_s = 2'b01;
    end else begin
      fwd_be_s = 2'b00;
    end
    fwd_ad_s      = src_hit(HSC_RsD, HSC_WriteRegM, HSC_RegWriteM);
    fwd_bd_s      = src_hit(HSC_RtD, HSC_WriteRegM, HSC_RegWriteM);
    lwstall_s     = HSC_MemToRegE && (HSC_RtE != 5'd0) &&
                    ((HSC_RtE == HSC_RsD) || (HSC_RtE == HSC_RtD));
    branchstall_s = HSC_BranchD &&
                    (src_hit(HSC_RsD, HSC_WriteRegE, HSC_RegWriteE) ||
                     src_hit(HSC_RtD, HSC_WriteRegE, HSC_RegWriteE) ||
                     src_hit(HSC_RsD, HSC_WriteRegM, HSC_MemToRegM) ||
                     src_hit(HSC_RtD, HSC_WriteRegM, HSC_MemToRegM));
    memstall_s    = (HSC_MemReqM && !HSC_MemReadyM) || (state_r == ERROR);
    stall_any_s   = !HSC_RST && (lwstall_s || branchstall_s || memstall_s);
  end

  // Drive pipeline controls; everything is held inactive during reset. A memory
  // stall suppresses the execute flush so the held instruction is not lost.
  always_comb begin
    HSC_StallF    = 1'b0;
    HSC_StallD    = 1'b0;
    HSC_StallE    = 1'b0;
    HSC_StallM    = 1'b0;
    HSC_FlushE    = 1'b0;
    HSC_FlushW    = 1'b0;
    HSC_ForwardAD = 1'b0;
    HSC_ForwardBD = 1'b0;
    HSC_ForwardAE = 2'b00;
    HSC_ForwardBE = 2'b00;
    if (HSC_RST) begin
      HSC_StallF = 1'b0;
    end else begin
      HSC_StallF    = stall_any_s;
      HSC_StallD    = stall_any_s;
      HSC_StallE    = memstall_s;
      HSC_StallM    = memstall_s;
      HSC_FlushW    = memstall_s;
      HSC_FlushE    = (lwstall_s || branchstall_s) && !memstall_s;
      HSC_ForwardAD = fwd_ad_s;
      HSC_ForwardBD = fwd_bd_s;
      HSC_ForwardAE = fwd_ae_s;
      HSC_ForwardBE = fwd_be_s;
    end
  end

  // Memory-wait sequencer: count consecutive not-ready cycles, trap on timeout.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    timeout_nxt_s = timeout_r;
    case (state_r)
      IDLE: begin
        if (HSC_MemReqM && !HSC_MemReadyM) begin
          state_nxt_s = MEM_WAIT;
          cnt_nxt_s   = CNT_ONE;
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      MEM_WAIT: begin
        if (HSC_MemReadyM) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == TIMEOUT_C) begin
          state_nxt_s   = ERROR;
          timeout_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ERROR: begin
        state_nxt_s   = ERROR;
        timeout_nxt_s = 1'b1;
      end
      default: begin
        state_nxt_s   = ERROR;
        timeout_nxt_s = 1'b1;
      end
    endcase
  end

  // Sequencer state, wait counter and sticky timeout flag.
  always_ff @(posedge HSC_CLK or posedge HSC_RST) begin
    if (HSC_RST) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      timeout_r <= timeout_nxt_s;
    end
  end

  // Saturating count of cycles spent with fetch stalled.
  always_ff @(posedge HSC_CLK or posedge HSC_RST) begin
    if (HSC_RST) begin
      stall_cnt_r <= 16'h0000;
    end else if (stall_any_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign HSC_MemTimeout = timeout_r;
  assign HSC_StallCount = stall_cnt_r;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed self-checking bench for hazard_stall_controller (TIMEOUT=4).
module tb_hazard_stall_controller;

  logic        clk, rst;
  logic [4:0]  rsd, rtd, rse, rte, wre, wrm, wrw;
  logic        rwe, rwm, rww, m2re, m2rm, brd, req, rdy;
  logic        stall_f, stall_d, stall_e, stall_m, flush_e, flush_w;
  logic        fwd_ad, fwd_bd, timeout;
  logic [1:0]  fwd_ae, fwd_be;
  logic [15:0] stall_count;
  logic [5:0]  ctl;

  int errors = 0;
  int checks = 0;

  assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_e, flush_w};

  hazard_stall_controller #(.TIMEOUT(4), .CNT_W(8)) dut (
    .HSC_CLK(clk), .HSC_RST(rst),
    .HSC_RsD(rsd), .HSC_RtD(rtd), .HSC_RsE(rse), .HSC_RtE(rte),
    .HSC_WriteRegE(wre), .HSC_WriteRegM(wrm), .HSC_WriteRegW(wrw),
    .HSC_RegWriteE(rwe), .HSC_RegWriteM(rwm), .HSC_RegWriteW(rww),
    .HSC_MemToRegE(m2re), .HSC_MemToRegM(m2rm), .HSC_BranchD(brd),
    .HSC_MemReqM(req), .HSC_MemReadyM(rdy),
    .HSC_StallF(stall_f), .HSC_StallD(stall_d), .HSC_StallE(stall_e),
    .HSC_StallM(stall_m), .HSC_FlushE(flush_e), .HSC_FlushW(flush_w),
    .HSC_ForwardAD(fwd_ad), .HSC_ForwardBD(fwd_bd),
    .HSC_ForwardAE(fwd_ae), .HSC_ForwardBE(fwd_be),
    .HSC_MemTimeout(timeout), .HSC_StallCount(stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clear_inputs();
    rsd = 5'd0; rtd = 5'd0; rse = 5'd0; rte = 5'd0;
    wre = 5'd0; wrm = 5'd0; wrw = 5'd0;
    rwe = 1'b0; rwm = 1'b0; rww = 1'b0; m2re = 1'b0; m2rm = 1'b0;
    brd = 1'b0; req = 1'b0; rdy = 1'b0;
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    m2re = 1'b1; rte = 5'd8; rsd = 5'd8; req = 1'b1;
    rse = 5'd5; wrm = 5'd5; rwm = 1'b1;
    #1;
    checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, 6'b000000); end
    checks++; if (fwd_ae !== 2'b00) begin errors++; $display("FAIL reset_fwd_ae: got %b expected %b", fwd_ae, 2'b00); end
    @(posedge clk); @(posedge clk); #1;
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    checks++; if (stall_count !== 16'h0000) begin errors++; $display("FAIL reset_count: got %h expected 0000", stall_count); end
    #1 rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    rse = 5'd5; rte = 5'd5; wrm = 5'd5; rwm = 1'b1; wrw = 5'd5; rww = 1'b1; rsd = 5'd5;
    #1;
    checks++; if (fwd_ae !== 2'b10) begin errors++; $display("FAIL fwd_ae_m: got %b expected 10", fwd_ae); end
    checks++; if (fwd_be !== 2'b10) begin errors++; $display("FAIL fwd_be_m: got %b expected 10", fwd_be); end
    checks++; if (fwd_ad !== 1'b1) begin errors++; $display("FAIL fwd_ad: got %b expected 1", fwd_ad); end
    rwm = 1'b0;
    #1;
    checks++; if (fwd_ae !== 2'b01) begin errors++; $display("FAIL fwd_ae_w: got %b expected 01", fwd_ae); end
    checks++; if (fwd_ad !== 1'b0) begin errors++; $display("FAIL fwd_ad_off: got %b expected 0", fwd_ad); end
    rse = 5'd0; wrw = 5'd0;
    #1;
    checks++; if (fwd_ae !== 2'b00) begin errors++; $display("FAIL fwd_ae_r0: got %b expected 00", fwd_ae); end
    checks++; if (fwd_be !== 2'b00) begin errors++; $display("FAIL fwd_be_none: got %b expected 00", fwd_be); end
    clear_inputs();
    step();
  endtask

  task automatic test_load_use();
    clear_inputs();
    m2re = 1'b1; rte = 5'd8; rsd = 5'd8;
    #1;
    checks++; if (ctl !== 6'b110010) begin errors++; $display("FAIL lw_rs: got %b expected %b", ctl, 6'b110010); end
    step();
    m2re = 1'b0;
    #1;
    checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL lw_release: got %b expected %b", ctl, 6'b000000); end
    m2re = 1'b1; rte = 5'd9; rsd = 5'd1; rtd = 5'd9;
    #1;
    checks++; if (ctl !== 6'b110010) begin errors++; $display("FAIL lw_rt: got %b expected %b", ctl, 6'b110010); end
    rte = 5'd0; rsd = 5'd0; rtd = 5'd0;
    #1;
    checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL lw_r0: got %b expected %b", ctl, 6'b000000); end
    clear_inputs();
    step();
  endtask

  task automatic test_branch();
    clear_inputs();
    brd = 1'b1; rwe = 1'b1; wre = 5'd3; rtd = 5'd3;
    #1;
    checks++; if (ctl !== 6'b110010) begin errors++; $display("FAIL br_e: got %b expected %b", ctl, 6'b110010); end
    step();
    rwe = 1'b0; wre = 5'd0; wrm = 5'd3; rwm = 1'b1; m2rm = 1'b0;
    #1;
    checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL br_clear: got %b expected %b", ctl, 6'b000000); end
    checks++; if (fwd_bd !== 1'b1) begin errors++; $display("FAIL br_fwd_bd: got %b expected 1", fwd_bd); end
    m2rm = 1'b1;
    #1;
    checks++; if (ctl !== 6'b110010) begin errors++; $display("FAIL br_load_m: got %b expected %b", ctl, 6'b110010); end
    clear_inputs();
    step();
  endtask

  task automatic test_mem_wait();
    do_reset();
    req = 1'b1; rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ctl !== 6'b111101) begin errors++; $display("FAIL memwait_cycle%0d: got %b expected %b", i, ctl, 6'b111101); end
      step();
    end
    rdy = 1'b1;
    #1;
    checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL memwait_ready: got %b expected %b", ctl, 6'b000000); end
    step();
    clear_inputs();
    #1;
    checks++; if (stall_count !== 16'd3) begin errors++; $display("FAIL memwait_count: got %0d expected 3", stall_count); end
    repeat (8) step();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL memwait_idle: got %b expected 0", timeout); end
  endtask

  task automatic test_ready_at_timeout();
    req = 1'b1; rdy = 1'b0;
    repeat (4) step();
    rdy = 1'b1;
    #1;
    checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL ready_wins_ctl: got %b expected %b", ctl, 6'b000000); end
    step();
    clear_inputs();
    repeat (8) step();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL ready_wins_timeout: got %b expected 0", timeout); end
    checks++; if (stall_count !== 16'd7) begin errors++; $display("FAIL ready_wins_count: got %0d expected 7", stall_count); end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 1'b1; rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if ({stall_f, timeout} !== 2'b10) begin errors++; $display("FAIL to_pre%0d: got %b expected 10", i, {stall_f, timeout}); end
      step();
    end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_flag: got %b expected 1", timeout); end
    checks++; if (stall_count !== 16'd5) begin errors++; $display("FAIL to_count: got %0d expected 5", stall_count); end
    rdy = 1'b1; req = 1'b0; m2re = 1'b1; rte = 5'd8; rsd = 5'd8;
    #1;
    checks++; if (ctl !== 6'b111101) begin errors++; $display("FAIL to_hold: got %b expected %b", ctl, 6'b111101); end
    step(); step();
    checks++; if (ctl !== 6'b111101) begin errors++; $display("FAIL to_absorb: got %b expected %b", ctl, 6'b111101); end
    #1 rst = 1'b1;
    #1;
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_async_flag: got %b expected 0", timeout); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL to_async_count: got %0d expected 0", stall_count); end
    checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL to_async_ctl: got %b expected %b", ctl, 6'b000000); end
    step();
    rst = 1'b0;
    clear_inputs();
    #1;
    checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL to_after_reset: got %b expected %b", ctl, 6'b000000); end
  endtask

  task automatic test_saturation();
    do_reset();
    m2re = 1'b1; rte = 5'd8; rsd = 5'd8;
    repeat (65534) @(posedge clk);
    #3;
    checks++; if (stall_count !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %h expected FFFE", stall_count); end
    @(posedge clk); #3;
    checks++; if (stall_count !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h expected FFFF", stall_count); end
    repeat (4500) @(posedge clk);
    #3;
    checks++; if (stall_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h expected FFFF", stall_count); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_ready_at_timeout();
    test_timeout();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Pipeline hazard and stall controller for the five-stage MIPS core. It computes forwarding selects for the decode-stage branch comparator and the execute-stage ALU, plus load-use and branch stalls. It also sequences multi-cycle data-memory accesses through a ready handshake, with a timeout watchdog and a stall-cycle performance counter. It sits beside the pipeline and drives the stall, flush and forward controls of the fetch, decode, execute, memory and writeback registers.

## Interface
- TIMEOUT, 16, maximum consecutive not-ready memory cycles tolerated (≥2)
- CNT_W, 8, width of wait counter (2^CNT_W > TIMEOUT)
- HSC_CLK  in  1  clock; all state updates on rising edge
- HSC_RST  in  1  reset; asynchronous, active-high
- HSC_RsD, HSC_RtD  in  5  decode-stage source registers
- HSC_RsE, HSC_RtE  in  5  execute-stage source registers
- HSC_WriteRegE, HSC_WriteRegM, HSC_WriteRegW  in  5  destination registers per stage
- HSC_RegWriteE, HSC_RegWriteM, HSC_RegWriteW  in  1  register-write enables per stage
- HSC_MemToRegE, HSC_MemToRegM  in  1  load in execute / memory stage
- HSC_BranchD  in  1  branch instruction in decode
- HSC_MemReqM  in  1  memory stage performs a load or store
- HSC_MemReadyM  in  1  data memory completes the access this cycle
- HSC_StallF, HSC_StallD  out  1  hold fetch/decode registers
- HSC_StallE, HSC_StallM  out  1  hold execute/memory registers
- HSC_FlushE  out  1  insert bubble into execute register
- HSC_FlushW  out  1  insert bubble into writeback register
- HSC_ForwardAD, HSC_ForwardBD  out  1  select ALU result from M for branch comparator operands
- HSC_ForwardAE, HSC_ForwardBE  out  2  ALU operand select: 00 register file, 01 ResultW, 10 ALUOutM
- HSC_MemTimeout  out  1  sticky watchdog error
- HSC_StallCount  out  16  saturating count of cycles with HSC_StallF high

## Operation
- Register 0 is never a hazard. Every compare below also requires the source register to be nonzero.
- Execute forwarding (A shown; B identical with RtE):
  - ForwardAE=10 if RsE==WriteRegM and RegWriteM.
  - Otherwise 01 if RsE==WriteRegW and RegWriteW.
  - Otherwise 00. M has priority over W.
- ForwardAD=1 if RsD==WriteRegM and RegWriteM; ForwardBD likewise with RtD.
- lwstall = MemToRegE and RtE≠0 and (RtE==RsD or RtE==RtD).
- branchstall = BranchD and either:
  - RegWriteE and WriteRegE≠0 and WriteRegE matches RsD or RtD, or
  - MemToRegM and WriteRegM≠0 and WriteRegM matches RsD or RtD.
- memstall = (MemReqM and not MemReadyM) or state==ERROR.
- StallF = StallD = lwstall | branchstall | memstall.
- StallE = StallM = FlushW = memstall.
- FlushE = (lwstall | branchstall) and not memstall. memstall dominates so execute contents are never lost.
- FSM states: IDLE, MEM_WAIT, ERROR.
  - IDLE: MemReqM and not MemReadyM → MEM_WAIT, wait counter = 1. Otherwise stay, counter = 0.
  - MEM_WAIT: MemReadyM → IDLE, counter = 0. Else if counter==TIMEOUT → ERROR, MemTimeout=1. Else counter+1.
  - ERROR: absorbing until reset. All stalls held high, FlushE=0, FlushW=1.
- The wait counter does not wrap; TIMEOUT is bounded by CNT_W.
- HSC_StallCount increments on each edge where StallF is high, saturating at 0xFFFF.
- While HSC_RST is high:
  - State=IDLE, counter=0, MemTimeout=0, StallCount=0.
  - All stall, flush and forward outputs are forced 0.

## Timing
- Hazard, forward, stall and flush outputs are combinational from current inputs and state, with zero-cycle latency. They are valid in the same cycle the condition appears.
- The first not-ready cycle stalls immediately via memstall, before the FSM leaves IDLE.
- MemReadyM high in any MEM_WAIT cycle releases the stall that same cycle. The FSM is IDLE after the edge.
- Ready arriving in the cycle where counter==TIMEOUT returns to IDLE, not ERROR (ready wins).
- ERROR is entered on the edge ending the (TIMEOUT+1)-th consecutive not-ready cycle. MemTimeout rises on that edge.
- Asynchronous reset mid-MEM_WAIT or in ERROR returns to IDLE immediately with all registered outputs cleared.
- Simultaneous lwstall and memstall: StallF/D/E/M=1, FlushE=0, FlushW=1. lwstall is re-evaluated after memory completes.

## Test plan
- Forwarding: RsE=5, WriteRegM=5, RegWriteM=1, WriteRegW=5, RegWriteW=1 → ForwardAE=10. Repeat with RegWriteM=0 → 01. Repeat with RsE=0 → 00.
- Load-use: MemToRegE=1, RtE=8, RsD=8 → StallF=StallD=FlushE=1, StallE=0. One cycle later with MemToRegE=0 → all 0.
- Branch: BranchD=1, RegWriteE=1, WriteRegE=3, RtD=3 → branchstall asserted. Next cycle WriteRegM=3, RegWriteM=1, MemToRegM=0 → stall clear, ForwardBD=1.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles then 1 → StallF/D/E/M and FlushW high for 3 cycles, low on the 4th. FSM back in IDLE. StallCount=3.
- Timeout with TIMEOUT=4: MemReqM=1, MemReadyM=0 held → MemTimeout=1 after 5th edge. Stalls stay high after MemReadyM rises. Asserting HSC_RST clears MemTimeout and StallCount asynchronously.
- Saturation: force 70000 stall cycles → StallCount stops at 0xFFFF.
